lenet_axi4lite_slave: RTL and testbench
=======================================

Name: lenet_axi4lite_slave

Overview:
- AXI4-Lite slave register front-end of the LeNet accelerator IP; the responder to the host/VIP master that loads the network and polls for a result.
- Decodes the register map and converts word writes into three valid/ready byte streams (weights, biases, pixels) toward the LeNet core.
- Sequences core start, exposes done, class result and load counters for read-back.

Parameters:
- ADDR_W, 5, AXI address width (byte address, word-aligned map 0x00-0x1C)
- N_WEIGHTS, 3220, weight words accepted per load
- N_BIAS, 10, bias words accepted per load
- N_PIXELS, 784, pixel words accepted per load

Ports:
- S_AXI_ACLK  in  1  clock
- S_AXI_ARESETN  in  1  asynchronous active-low reset
- S_AXI_AWADDR/AWPROT/AWVALID  in  ADDR_W/3/1; S_AXI_AWREADY  out  1
- S_AXI_WDATA/WSTRB/WVALID  in  32/4/1; S_AXI_WREADY  out  1
- S_AXI_BRESP  out  2; S_AXI_BVALID  out  1; S_AXI_BREADY  in  1
- S_AXI_ARADDR/ARPROT/ARVALID  in  ADDR_W/3/1; S_AXI_ARREADY  out  1
- S_AXI_RDATA  out  32; S_AXI_RRESP  out  2; S_AXI_RVALID  out  1; S_AXI_RREADY  in  1
- wgt_data  out  8  signed weight (WDATA[7:0]); wgt_valid  out  1; wgt_ready  in  1
- bias_data  out  16  signed bias (WDATA[15:0]); bias_valid  out  1; bias_ready  in  1
- pix_data  out  8  unsigned pixel (WDATA[7:0]); pix_valid  out  1; pix_ready  in  1
- core_start  out  1  one-cycle start pulse
- core_srst  out  1  level soft reset to core
- core_done  in  1  one-cycle completion pulse
- core_result  in  4  class index, valid with core_done

Behaviour:
- Reset: all READY/VALID outputs 0, BRESP/RRESP 2'b00, RDATA 0, stream valids 0, core_start 0, core_srst 0, counters/done/result/start_pending 0.
- Map: 0x00 CTRL (W bit0=1 sets start_pending; R {31'b0,start_pending}); 0x04 WEIGHT push; 0x08 BIAS push; 0x0C PIXEL push; 0x10 STATUS R {6'b0,pix_cnt[9:0],bias_cnt[3:0],wgt_cnt[11:0]}; 0x14 DONE R bit0; 0x18 RESULT R [3:0]; 0x1C SRST R/W bit0 -> core_srst. WSTRB ignored. Unmapped or read-only write: OKAY, no effect; unmapped or push-register read: 0, OKAY.
- Write FSM W_IDLE/W_PUSH/W_RESP: in W_IDLE AWREADY=1 until AW latched, WREADY=1 until W latched, independently (single-cycle ready pulses on handshake). Both latched -> push register: W_PUSH, else register effect applied, W_RESP next cycle.
- W_PUSH: matching *_valid=1 with data held stable until *_ready; on handshake counter +1, valid drops, W_RESP next cycle. Minimum AW/W handshake to BVALID = 2 cycles for push with ready=1, 1 cycle otherwise.
- Push rejected (no valid asserted, BRESP=2'b10 SLVERR, straight to W_RESP) when counter already equals N_* or core_srst=1.
- W_RESP: BVALID=1 until BREADY, then W_IDLE. No new AW/W accepted until then.
- Start: when start_pending=1 and wgt_cnt==N_WEIGHTS, bias_cnt==N_BIAS, pix_cnt==N_PIXELS, core_srst=0: core_start=1 for exactly one cycle, start_pending cleared, done cleared. Start written before or after loading both valid.
- core_done pulse: done<=1 (sticky), result<=core_result. Same-cycle start and core_done: done cleared wins.
- core_srst=1 (write 1 to 0x1C): counters, start_pending, done, result cleared and held clear while asserted; writing 0 releases.
- Read FSM R_IDLE/R_DATA: ARREADY=1 in R_IDLE; on handshake RDATA sampled from register file, RVALID=1 next cycle, held with stable data until RREADY. Reads and writes progress independently.
- Counters never wrap; ARESETN deassert mid-transaction aborts everything to reset values.

Test Plan:
- Write 0x1C=0,1,0 then read 0x1C, 0x10 -> 0, 0x00000000, BRESP OKAY each.
- Write 0x00=1, 3220x 0x04, 10x 0x08, 784x 0x0C, ready=1 -> single core_start pulse one cycle after the 784th pixel handshake; STATUS=0x0310AC94.
- Hold wgt_ready=0 for 20 cycles during 0x04 write -> wgt_valid held, data stable, BVALID only after ready; BREADY held low 5 cycles -> BVALID held.
- 3221st weight write -> BRESP=2'b10, no wgt_valid, wgt_cnt stays 3220.
- core_done with core_result=7 -> read 0x14=1, 0x18=7; write 0x1C=1 -> both read 0.
- AW 3 cycles before W, and ARVALID concurrent with a write -> both complete correctly with OKAY.

Source files
------------

// File: rtl/lenet_axi4lite_slave.sv
// AXI4-Lite register front-end for the LeNet accelerator: decodes the register map,
// turns pushed words into weight/bias/pixel byte streams and sequences core start.
module lenet_axi4lite_slave #(
  parameter int ADDR_W    = 5,
  parameter int N_WEIGHTS = 3220,
  parameter int N_BIAS    = 10,
  parameter int N_PIXELS  = 784
) (
  input  logic              S_AXI_ACLK,
  input  logic              S_AXI_ARESETN,
  input  logic [ADDR_W-1:0] S_AXI_AWADDR,
  input  logic [2:0]        S_AXI_AWPROT,
  input  logic              S_AXI_AWVALID,
  output logic              S_AXI_AWREADY,
  input  logic [31:0]       S_AXI_WDATA,
  input  logic [3:0]        S_AXI_WSTRB,
  input  logic              S_AXI_WVALID,
  output logic              S_AXI_WREADY,
  output logic [1:0]        S_AXI_BRESP,
  output logic              S_AXI_BVALID,
  input  logic              S_AXI_BREADY,
  input  logic [ADDR_W-1:0] S_AXI_ARADDR,
  input  logic [2:0]        S_AXI_ARPROT,
  input  logic              S_AXI_ARVALID,
  output logic              S_AXI_ARREADY,
  output logic [31:0]       S_AXI_RDATA,
  output logic [1:0]        S_AXI_RRESP,
  output logic              S_AXI_RVALID,
  input  logic              S_AXI_RREADY,
  output logic [7:0]        wgt_data,
  output logic              wgt_valid,
  input  logic              wgt_ready,
  output logic [15:0]       bias_data,
  output logic              bias_valid,
  input  logic              bias_ready,
  output logic [7:0]        pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              core_start,
  output logic              core_srst,
  input  logic              core_done,
  input  logic [3:0]        core_result
);

  localparam int IW = ADDR_W - 2;
  localparam logic [IW-1:0] REG_CTRL = IW'(0);
  localparam logic [IW-1:0] REG_WGT  = IW'(1);
  localparam logic [IW-1:0] REG_BIAS = IW'(2);
  localparam logic [IW-1:0] REG_PIX  = IW'(3);
  localparam logic [IW-1:0] REG_STAT = IW'(4);
  localparam logic [IW-1:0] REG_DONE = IW'(5);
  localparam logic [IW-1:0] REG_RES  = IW'(6);
  localparam logic [IW-1:0] REG_SRST = IW'(7);

  typedef enum logic [1:0] {W_IDLE, W_PUSH, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  wstate_t       wstate;
  rstate_t       rstate;
  logic          aw_done, w_done;
  logic [IW-1:0] aw_idx;
  logic [15:0]   wdata_q;
  logic [11:0]   wgt_cnt;
  logic [3:0]    bias_cnt;
  logic [9:0]    pix_cnt;
  logic          start_pending, done;
  logic [3:0]    result;
  logic [31:0]   rd_mux;

  logic wgt_full, bias_full, pix_full, is_push, push_full, push_hs, start_fire;

  assign wgt_full  = (wgt_cnt == 12'(N_WEIGHTS));
  assign bias_full = (bias_cnt == 4'(N_BIAS));
  assign pix_full  = (pix_cnt == 10'(N_PIXELS));
  assign is_push   = (aw_idx == REG_WGT) || (aw_idx == REG_BIAS) || (aw_idx == REG_PIX);
  assign push_full = ((aw_idx == REG_WGT) && wgt_full) || ((aw_idx == REG_BIAS) && bias_full) ||
                     ((aw_idx == REG_PIX) && pix_full);
  assign push_hs   = (wgt_valid && wgt_ready) || (bias_valid && bias_ready) || (pix_valid && pix_ready);
  assign start_fire = start_pending && wgt_full && bias_full && pix_full && !core_srst;

  assign wgt_data  = wdata_q[7:0];
  assign bias_data = wdata_q;
  assign pix_data  = wdata_q[7:0];

  logic unused_inputs;
  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_WSTRB, S_AXI_AWADDR[1:0],
                           S_AXI_ARADDR[1:0], S_AXI_WDATA[31:16]};

  // Write channel, push streams and core sequencing share one block since they all own the counters.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      wstate        <= W_IDLE;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      aw_idx        <= '0;
      wdata_q       <= '0;
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BRESP   <= 2'b00;
      S_AXI_BVALID  <= 1'b0;
      wgt_valid     <= 1'b0;
      bias_valid    <= 1'b0;
      pix_valid     <= 1'b0;
      wgt_cnt       <= '0;
      bias_cnt      <= '0;
      pix_cnt       <= '0;
      start_pending <= 1'b0;
      done          <= 1'b0;
      result        <= '0;
      core_start    <= 1'b0;
      core_srst     <= 1'b0;
    end else begin
      core_start <= 1'b0;
      case (wstate)
        W_IDLE: begin
          if (aw_done && w_done) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            if (is_push && (push_full || core_srst)) begin
              S_AXI_BRESP  <= 2'b10;
              S_AXI_BVALID <= 1'b1;
              wstate       <= W_RESP;
            end else if (is_push) begin
              wgt_valid  <= (aw_idx == REG_WGT);
              bias_valid <= (aw_idx == REG_BIAS);
              pix_valid  <= (aw_idx == REG_PIX);
              wstate     <= W_PUSH;
            end else begin
              case (aw_idx)
                REG_CTRL: if (wdata_q[0]) start_pending <= 1'b1;
                REG_SRST: core_srst <= wdata_q[0];
                default: ;
              endcase
              S_AXI_BRESP  <= 2'b00;
              S_AXI_BVALID <= 1'b1;
              wstate       <= W_RESP;
            end
          end else begin
            if (S_AXI_AWREADY && S_AXI_AWVALID) begin
              aw_done       <= 1'b1;
              aw_idx        <= S_AXI_AWADDR[ADDR_W-1:2];
              S_AXI_AWREADY <= 1'b0;
            end else if (!aw_done) begin
              S_AXI_AWREADY <= 1'b1;
            end
            if (S_AXI_WREADY && S_AXI_WVALID) begin
              w_done       <= 1'b1;
              wdata_q      <= S_AXI_WDATA[15:0];
              S_AXI_WREADY <= 1'b0;
            end else if (!w_done) begin
              S_AXI_WREADY <= 1'b1;
            end
          end
        end
        W_PUSH: begin
          if (push_hs) begin
            if (wgt_valid)  wgt_cnt  <= wgt_cnt + 12'd1;
            if (bias_valid) bias_cnt <= bias_cnt + 4'd1;
            if (pix_valid)  pix_cnt  <= pix_cnt + 10'd1;
            wgt_valid    <= 1'b0;
            bias_valid   <= 1'b0;
            pix_valid    <= 1'b0;
            S_AXI_BRESP  <= 2'b00;
            S_AXI_BVALID <= 1'b1;
            wstate       <= W_RESP;
          end
        end
        W_RESP: begin
          if (S_AXI_BREADY) begin
            S_AXI_BVALID <= 1'b0;
            wstate       <= W_IDLE;
          end
        end
        default: wstate <= W_IDLE;
      endcase

      if (core_done) begin
        done   <= 1'b1;
        result <= core_result;
      end
      // A start in the same cycle as a completion pulse wins, so done reads back clear.
      if (start_fire) begin
        core_start    <= 1'b1;
        start_pending <= 1'b0;
        done          <= 1'b0;
      end
      if (core_srst) begin
        wgt_cnt       <= '0;
        bias_cnt      <= '0;
        pix_cnt       <= '0;
        start_pending <= 1'b0;
        done          <= 1'b0;
        result        <= '0;
      end
    end
  end

  always_comb begin
    rd_mux = 32'd0;
    case (S_AXI_ARADDR[ADDR_W-1:2])
      REG_CTRL: rd_mux = {31'd0, start_pending};
      REG_STAT: rd_mux = {6'd0, pix_cnt, bias_cnt, wgt_cnt};
      REG_DONE: rd_mux = {31'd0, done};
      REG_RES:  rd_mux = {28'd0, result};
      REG_SRST: rd_mux = {31'd0, core_srst};
      default:  rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      rstate        <= R_IDLE;
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RDATA   <= 32'd0;
      S_AXI_RRESP   <= 2'b00;
      S_AXI_RVALID  <= 1'b0;
    end else begin
      case (rstate)
        R_IDLE: begin
          if (S_AXI_ARREADY && S_AXI_ARVALID) begin
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RDATA   <= rd_mux;
            S_AXI_RRESP   <= 2'b00;
            S_AXI_RVALID  <= 1'b1;
            rstate        <= R_DATA;
          end else begin
            S_AXI_ARREADY <= 1'b1;
          end
        end
        R_DATA: begin
          if (S_AXI_RREADY) begin
            S_AXI_RVALID  <= 1'b0;
            S_AXI_ARREADY <= 1'b1;
            rstate        <= R_IDLE;
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lenet_axi4lite_slave.sv
// Scoreboard bench for lenet_axi4lite_slave: expected responses and stream bytes are queued
// when a transaction is issued and retired when the DUT answers.
module tb_lenet_axi4lite_slave;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  awaddr = '0, araddr = '0;
  logic [2:0]  awprot = '0, arprot = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = 4'hF;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic [7:0]  wgt_data, pix_data;
  logic [15:0] bias_data;
  logic        wgt_valid, bias_valid, pix_valid;
  logic        wgt_ready = 1'b1, bias_ready = 1'b1, pix_ready = 1'b1;
  logic        core_start, core_srst;
  logic        core_done = 1'b0;
  logic [3:0]  core_result = '0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cnt = 0, start_cyc = 0, last_pix_cyc = 0, wgt_valid_cycles = 0;

  logic [31:0] bresp_q[$];
  logic [31:0] rd_q[$];
  logic [31:0] wgt_q[$];
  logic [31:0] bias_q[$];
  logic [31:0] pix_q[$];

  lenet_axi4lite_slave dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .wgt_data(wgt_data), .wgt_valid(wgt_valid), .wgt_ready(wgt_ready),
    .bias_data(bias_data), .bias_valid(bias_valid), .bias_ready(bias_ready),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .core_start(core_start), .core_srst(core_srst), .core_done(core_done), .core_result(core_result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Stream side of the scoreboard: every accepted byte must match the oldest queued push.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wgt_valid) wgt_valid_cycles++;
      if (wgt_valid && wgt_ready) begin
        checkOutput("wgt_q_depth", wgt_q.size(), 1);
        if (wgt_q.size() > 0) checkOutput("wgt_data", {24'd0, wgt_data}, {24'd0, wgt_q.pop_front()});
      end
      if (bias_valid && bias_ready) begin
        checkOutput("bias_q_depth", bias_q.size(), 1);
        if (bias_q.size() > 0) checkOutput("bias_data", {16'd0, bias_data}, {16'd0, bias_q.pop_front()});
      end
      if (pix_valid && pix_ready) begin
        checkOutput("pix_q_depth", pix_q.size(), 1);
        if (pix_q.size() > 0) checkOutput("pix_data", {24'd0, pix_data}, {24'd0, pix_q.pop_front()});
        last_pix_cyc = cyc;
      end
      if (core_start) begin
        start_cnt++;
        start_cyc = cyc;
      end
    end
  end

  // AXI write: W is presented w_delay cycles after AW, BREADY held low bready_delay cycles of BVALID.
  task automatic applyStimulus(input string tag, input logic [4:0] addr, input logic [31:0] data,
                               input logic [1:0] exp_resp, input int w_delay, input int bready_delay);
    int  k;
    int  held;
    bit  aw_ok, w_ok, hs_aw, hs_w, b_ok;
    bresp_q.push_back({30'd0, exp_resp});
    if (exp_resp == 2'b00) begin
      if (addr == 5'h04) wgt_q.push_back({24'd0, data[7:0]});
      if (addr == 5'h08) bias_q.push_back({16'd0, data[15:0]});
      if (addr == 5'h0C) pix_q.push_back({24'd0, data[7:0]});
    end
    @(posedge clk); #1;
    awaddr = addr; awvalid = 1'b1;
    if (w_delay == 0) begin wdata = data; wvalid = 1'b1; end
    aw_ok = 0; w_ok = 0; k = 0;
    while (!(aw_ok && w_ok) && k < 200) begin
      @(negedge clk);
      hs_aw = awvalid && awready;
      hs_w  = wvalid && wready;
      @(posedge clk); #1;
      k++;
      if (hs_aw) begin awvalid = 1'b0; aw_ok = 1; end
      if (hs_w) begin wvalid = 1'b0; w_ok = 1; end
      if (k == w_delay && !w_ok) begin wdata = data; wvalid = 1'b1; end
    end
    if (!(aw_ok && w_ok)) begin
      awvalid = 1'b0; wvalid = 1'b0;
      checkOutput({tag, "_aw_w_timeout"}, {30'd0, aw_ok, w_ok}, 32'd3);
      void'(bresp_q.pop_front());
      return;
    end
    bready = (bready_delay == 0);
    held = 0; k = 0; b_ok = 0;
    while (!b_ok && k < 200) begin
      @(negedge clk);
      k++;
      if (bvalid && bready) begin
        checkOutput({tag, "_bresp"}, {30'd0, bresp}, bresp_q.pop_front());
        if (bready_delay > 0) checkOutput({tag, "_bvalid_held"}, held, bready_delay);
        b_ok = 1;
        @(posedge clk); #1;
        bready = 1'b0;
      end else if (bvalid) begin
        held++;
        if (held == bready_delay) begin @(posedge clk); #1; bready = 1'b1; end
      end
    end
    if (!b_ok) begin
      bready = 1'b0;
      checkOutput({tag, "_b_timeout"}, {31'd0, bvalid}, 32'd1);
      void'(bresp_q.pop_front());
    end
  endtask

  task automatic axi_read(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    int k;
    bit hs, r_ok;
    rd_q.push_back(exp);
    @(posedge clk); #1;
    araddr = addr; arvalid = 1'b1; rready = 1'b1;
    hs = 0; k = 0;
    while (!hs && k < 200) begin
      @(negedge clk);
      hs = arvalid && arready;
      @(posedge clk); #1;
      k++;
    end
    arvalid = 1'b0;
    if (!hs) begin
      checkOutput({tag, "_ar_timeout"}, {31'd0, arready}, 32'd1);
      void'(rd_q.pop_front());
      return;
    end
    r_ok = 0; k = 0;
    while (!r_ok && k < 200) begin
      @(negedge clk);
      k++;
      if (rvalid) begin
        checkOutput({tag, "_rdata"}, rdata, rd_q.pop_front());
        checkOutput({tag, "_rresp"}, {30'd0, rresp}, 32'd0);
        r_ok = 1;
      end
    end
    if (!r_ok) begin
      checkOutput({tag, "_r_timeout"}, {31'd0, rvalid}, 32'd1);
      void'(rd_q.pop_front());
    end
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  initial begin
    int  k;
    bit  stable, early_b;
    int  vcyc;
    logic [31:0] d;

    repeat (3) @(negedge clk);
    checkOutput("reset_ready", {28'd0, awready, wready, arready, bvalid}, 32'd0);
    checkOutput("reset_valid", {28'd0, rvalid, wgt_valid, bias_valid, pix_valid}, 32'd0);
    checkOutput("reset_core", {30'd0, core_start, core_srst}, 32'd0);
    checkOutput("reset_rdata", rdata, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    applyStimulus("srst0", 5'h1C, 32'd0, 2'b00, 0, 0);
    applyStimulus("srst1", 5'h1C, 32'd1, 2'b00, 0, 0);
    axi_read("rd_srst_on", 5'h1C, 32'd1);
    applyStimulus("srst0b", 5'h1C, 32'd0, 2'b00, 0, 0);
    axi_read("rd_srst", 5'h1C, 32'd0);
    axi_read("rd_status0", 5'h10, 32'd0);

    applyStimulus("ctrl", 5'h00, 32'd1, 2'b00, 0, 0);
    axi_read("rd_ctrl_pend", 5'h00, 32'd1);

    // First weight: stall the stream 20 cycles and the B channel 5 cycles.
    wgt_ready = 1'b0;
    fork
      applyStimulus("wgt_stall", 5'h04, 32'h0000_00A5, 2'b00, 0, 5);
      begin
        k = 0;
        do begin @(negedge clk); k++; end while (!wgt_valid && k < 50);
        checkOutput("wgt_valid_rise", {31'd0, wgt_valid}, 32'd1);
        checkOutput("wgt_stall_data", {24'd0, wgt_data}, 32'h0000_00A5);
        stable = 1; early_b = 0;
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          if (!wgt_valid || wgt_data != 8'hA5) stable = 0;
          if (bvalid) early_b = 1;
        end
        checkOutput("wgt_hold_stable", {31'd0, stable}, 32'd1);
        checkOutput("bvalid_before_ready", {31'd0, early_b}, 32'd0);
        @(posedge clk); #1 wgt_ready = 1'b1;
      end
    join

    for (int i = 1; i < 3220; i++) begin
      d = $urandom();
      applyStimulus("wgt", 5'h04, d, 2'b00, 0, 0);
    end
    for (int i = 0; i < 10; i++) begin
      d = $urandom();
      applyStimulus("bias", 5'h08, d, 2'b00, 0, 0);
    end
    for (int i = 0; i < 783; i++) begin
      d = $urandom();
      applyStimulus("pix", 5'h0C, d, 2'b00, 0, 0);
    end
    repeat (3) @(posedge clk);
    checkOutput("start_not_early", start_cnt, 0);
    applyStimulus("pix_last", 5'h0C, 32'h0000_00FE, 2'b00, 0, 0);
    repeat (5) @(posedge clk);
    checkOutput("start_count", start_cnt, 1);
    checkOutput("start_latency", start_cyc - last_pix_cyc, 2);
    axi_read("rd_status_full", 5'h10, 32'h0310_AC94);
    axi_read("rd_ctrl_clr", 5'h00, 32'd0);

    vcyc = wgt_valid_cycles;
    applyStimulus("wgt_over", 5'h04, 32'h0000_0011, 2'b10, 0, 0);
    checkOutput("wgt_over_novalid", wgt_valid_cycles, vcyc);
    axi_read("rd_status_over", 5'h10, 32'h0310_AC94);

    @(posedge clk); #1 core_done = 1'b1; core_result = 4'd7;
    @(posedge clk); #1 core_done = 1'b0; core_result = 4'd0;
    axi_read("rd_done", 5'h14, 32'd1);
    axi_read("rd_result", 5'h18, 32'd7);

    applyStimulus("srst_set", 5'h1C, 32'd1, 2'b00, 0, 0);
    @(negedge clk);
    checkOutput("core_srst_level", {31'd0, core_srst}, 32'd1);
    axi_read("rd_done_clr", 5'h14, 32'd0);
    axi_read("rd_result_clr", 5'h18, 32'd0);
    axi_read("rd_status_clr", 5'h10, 32'd0);
    applyStimulus("wgt_in_srst", 5'h04, 32'h0000_0022, 2'b10, 0, 0);

    fork
      applyStimulus("srst_rel_late_w", 5'h1C, 32'd0, 2'b00, 3, 0);
      axi_read("rd_concurrent", 5'h18, 32'd0);
    join
    @(negedge clk);
    checkOutput("core_srst_release", {31'd0, core_srst}, 32'd0);
    axi_read("rd_srst_rel", 5'h1C, 32'd0);
    axi_read("rd_push_reg", 5'h04, 32'd0);
    applyStimulus("wr_readonly", 5'h10, 32'hFFFF_FFFF, 2'b00, 0, 0);
    axi_read("rd_status_ro", 5'h10, 32'd0);
    checkOutput("stream_q_empty", wgt_q.size() + bias_q.size() + pix_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
